// File: rtl/ddr2_return_buffer.sv
// Read-return FIFO between the DDR2 controller read path and a popping consumer.
// Optional sticky overflow/underflow flags are built only with DDR2_RETURN_BUFFER_ERR_FLAGS_EN.
module ddr2_return_buffer #(
    parameter int DATA_W     = 128,
    parameter int ADX_W      = 27,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_valid,
    input  logic [DATA_W-1:0]     rd_data,
    input  logic [ADX_W-1:0]      rd_adx,
    output logic                  rd_ready,
    output logic                  has_return_data,
    input  logic                  get_return_data,
    output logic [DATA_W-1:0]     return_data,
    output logic [ADX_W-1:0]      return_adx,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = DATA_W + ADX_W;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  full;

    assign empty           = (count == '0);
    assign full            = (count == FULL_COUNT);
    assign has_return_data = !empty;
    assign rd_ready        = !full;
    assign fill_level      = count;

    // A pop at count=0 is invalid even when a push lands the same edge: no bypass.
    assign push = rd_valid && !full;
    assign pop  = get_return_data && !empty;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {rd_adx, rd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            return_data <= '0;
            return_adx  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                {return_adx, return_data} <= mem[rd_ptr];
                rd_ptr                    <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef DDR2_RETURN_BUFFER_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (rd_valid && full) begin
                overflow <= 1'b1;
            end
            if (get_return_data && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_return_buffer.sv
// Self-checking bench for ddr2_return_buffer against a queue-based FIFO reference model.
module tb_ddr2_return_buffer;

    localparam int DATA_W     = 128;
    localparam int ADX_W      = 27;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic                rd_valid = 1'b0;
    logic [DATA_W-1:0]   rd_data = '0;
    logic [ADX_W-1:0]    rd_adx = '0;
    logic                rd_ready;
    logic                has_return_data;
    logic                get_return_data = 1'b0;
    logic [DATA_W-1:0]   return_data;
    logic [ADX_W-1:0]    return_adx;
    logic [DEPTH_LOG2:0] fill_level;
    logic                overflow;
    logic                underflow;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [DATA_W+ADX_W-1:0] q [$];
    logic [DATA_W-1:0]       exp_data = '0;
    logic [ADX_W-1:0]        exp_adx = '0;
    logic                    exp_ovf = 1'b0;
    logic                    exp_unf = 1'b0;

    ddr2_return_buffer #(
        .DATA_W(DATA_W), .ADX_W(ADX_W), .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_adx(rd_adx),
        .rd_ready(rd_ready),
        .has_return_data(has_return_data),
        .get_return_data(get_return_data),
        .return_data(return_data),
        .return_adx(return_adx),
        .fill_level(fill_level),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic void model_edge();
        bit was_full;
        bit was_empty;
        if (!resetn) begin
            q.delete();
            exp_data = '0;
            exp_adx  = '0;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
            return;
        end
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
`ifdef DDR2_RETURN_BUFFER_ERR_FLAGS_EN
        if (rd_valid && was_full) exp_ovf = 1'b1;
        if (get_return_data && was_empty) exp_unf = 1'b1;
`endif
        if (get_return_data && !was_empty) {exp_adx, exp_data} = q.pop_front();
        if (rd_valid && !was_full) q.push_back({rd_adx, rd_data});
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        rd_valid = 1'b0;
        get_return_data = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_word(input logic [ADX_W-1:0] a, input logic [DATA_W-1:0] d);
        rd_valid = 1'b1;
        rd_adx = a;
        rd_data = d;
        cycle();
        rd_valid = 1'b0;
    endtask

    task automatic pop_word();
        get_return_data = 1'b1;
        cycle();
        get_return_data = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (fill_level !== 0 || has_return_data !== 1'b0 || rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_init fill=%0d has=%b ready=%b exp fill=0 has=0 ready=1",
                     fill_level, has_return_data, rd_ready);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags ovf=%b unf=%b exp 0 0", overflow, underflow);
        end
        push_word(27'h10, 128'hA0);
        push_word(27'h11, 128'hA1);
        push_word(27'h12, 128'hA2);
        checks++;
        if (fill_level !== 3) begin
            failures++;
            $display("FAIL reset_prefill fill=%0d exp=3", fill_level);
        end
        // get high during reset must not complete a pop
        resetn = 1'b0;
        get_return_data = 1'b1;
        cycle();
        get_return_data = 1'b0;
        resetn = 1'b1;
        checks++;
        if (fill_level !== 0 || has_return_data !== 1'b0 || return_data !== '0 || return_adx !== '0) begin
            failures++;
            $display("FAIL reset_mid fill=%0d has=%b data=%h adx=%h exp all zero",
                     fill_level, has_return_data, return_data, return_adx);
        end
    endtask

    task automatic test_single();
        apply_reset();
        push_word(27'h0000123, 128'hDEADBEEF);
        checks++;
        if (has_return_data !== 1'b1 || fill_level !== 1) begin
            failures++;
            $display("FAIL single_has has=%b fill=%0d exp has=1 fill=1", has_return_data, fill_level);
        end
        pop_word();
        checks++;
        if (return_adx !== 27'h123 || return_data !== 128'hDEADBEEF) begin
            failures++;
            $display("FAIL single_pop adx=%h data=%h exp adx=123 data=deadbeef", return_adx, return_data);
        end
        checks++;
        if (has_return_data !== 1'b0 || fill_level !== 0) begin
            failures++;
            $display("FAIL single_empty has=%b fill=%0d exp has=0 fill=0", has_return_data, fill_level);
        end
    endtask

    task automatic test_fill_full();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) push_word(27'(i), rand_data());
        checks++;
        if (rd_ready !== 1'b0 || fill_level !== 5'd16) begin
            failures++;
            $display("FAIL full_state ready=%b fill=%0d exp ready=0 fill=16", rd_ready, fill_level);
        end
        push_word(27'd99, rand_data());
        checks++;
        if (fill_level !== 5'd16 || overflow !== exp_ovf) begin
            failures++;
            $display("FAIL full_drop fill=%0d ovf=%b exp fill=16 ovf=%b", fill_level, overflow, exp_ovf);
        end
        // push while full with a simultaneous pop: push still dropped
        rd_valid = 1'b1;
        rd_adx = 27'd98;
        rd_data = rand_data();
        get_return_data = 1'b1;
        cycle();
        rd_valid = 1'b0;
        get_return_data = 1'b0;
        checks++;
        if (fill_level !== 5'd15 || return_adx !== 27'd0) begin
            failures++;
            $display("FAIL full_push_pop fill=%0d adx=%0d exp fill=15 adx=0", fill_level, return_adx);
        end
        for (int i = 1; i < DEPTH; i++) begin
            pop_word();
            checks++;
            if (return_adx !== 27'(i) || return_data !== exp_data) begin
                failures++;
                $display("FAIL full_order adx=%0d data=%h exp adx=%0d data=%h",
                         return_adx, return_data, i, exp_data);
            end
        end
        checks++;
        if (fill_level !== 0 || rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_drain fill=%0d ready=%b exp 0 1", fill_level, rd_ready);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 10; i++) push_word(27'(i), rand_data());
        for (int i = 0; i < 10; i++) pop_word();
        for (int i = 0; i < 10; i++) push_word(27'(100 + i), rand_data());
        for (int i = 0; i < 10; i++) begin
            pop_word();
            checks++;
            if (return_adx !== 27'(100 + i) || return_data !== exp_data) begin
                failures++;
                $display("FAIL wrap_order adx=%0d data=%h exp adx=%0d data=%h",
                         return_adx, return_data, 100 + i, exp_data);
            end
        end
        checks++;
        if (fill_level !== 0) begin
            failures++;
            $display("FAIL wrap_fill fill=%0d exp=0", fill_level);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int i = 0; i < 5; i++) push_word(27'(200 + i), rand_data());
        rd_valid = 1'b1;
        rd_adx = 27'd300;
        rd_data = rand_data();
        get_return_data = 1'b1;
        cycle();
        rd_valid = 1'b0;
        get_return_data = 1'b0;
        checks++;
        if (fill_level !== 5 || return_adx !== 27'd200 || return_data !== exp_data) begin
            failures++;
            $display("FAIL simul fill=%0d adx=%0d data=%h exp fill=5 adx=200 data=%h",
                     fill_level, return_adx, return_data, exp_data);
        end
        // push+pop on an empty buffer: pop ignored, push lands
        apply_reset();
        rd_valid = 1'b1;
        rd_adx = 27'd55;
        rd_data = 128'h55;
        get_return_data = 1'b1;
        cycle();
        rd_valid = 1'b0;
        get_return_data = 1'b0;
        checks++;
        if (fill_level !== 1 || return_adx !== 27'd0 || return_data !== '0 || underflow !== exp_unf) begin
            failures++;
            $display("FAIL simul_empty fill=%0d adx=%h data=%h unf=%b exp fill=1 adx=0 data=0 unf=%b",
                     fill_level, return_adx, return_data, underflow, exp_unf);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        push_word(27'h77, 128'hCAFE);
        pop_word();
        pop_word();
        checks++;
        if (return_data !== 128'hCAFE || return_adx !== 27'h77 || fill_level !== 0) begin
            failures++;
            $display("FAIL underflow_hold data=%h adx=%h fill=%0d exp data=cafe adx=77 fill=0",
                     return_data, return_adx, fill_level);
        end
        checks++;
        if (underflow !== exp_unf || overflow !== exp_ovf) begin
            failures++;
            $display("FAIL underflow_flag unf=%b ovf=%b exp unf=%b ovf=%b", underflow, overflow, exp_unf, exp_ovf);
        end
    endtask

    task automatic test_pacing();
        logic [DATA_W-1:0] held_data;
        logic [ADX_W-1:0]  held_adx;
        apply_reset();
        for (int i = 0; i < 4; i++) push_word(27'(400 + i), rand_data());
        for (int e = 0; e < 4; e++) begin
            get_return_data = has_return_data;
            cycle();
            get_return_data = 1'b0;
            held_data = return_data;
            held_adx  = return_adx;
            checks++;
            if (return_adx !== 27'(400 + e) || return_data !== exp_data) begin
                failures++;
                $display("FAIL pacing_pop adx=%0d exp=%0d", return_adx, 400 + e);
            end
            for (int c = 1; c < 16; c++) begin
                cycle();
                checks++;
                if (return_data !== held_data || return_adx !== held_adx) begin
                    failures++;
                    $display("FAIL pacing_hold cycle=%0d adx=%h exp=%h", c, return_adx, held_adx);
                end
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            resetn = ($urandom_range(0, 99) != 0);
            rd_valid = ($urandom_range(0, 99) < 55);
            get_return_data = ($urandom_range(0, 99) < 45);
            rd_adx = 27'($urandom);
            rd_data = rand_data();
            cycle();
            checks++;
            if (fill_level !== 5'(q.size()) || has_return_data !== (q.size() != 0) ||
                rd_ready !== (q.size() != DEPTH) || return_data !== exp_data ||
                return_adx !== exp_adx || overflow !== exp_ovf || underflow !== exp_unf) begin
                failures++;
                $display("FAIL random n=%0d fill=%0d/%0d adx=%h/%h data=%h/%h ovf=%b/%b unf=%b/%b",
                         n, fill_level, q.size(), return_adx, exp_adx, return_data, exp_data,
                         overflow, exp_ovf, underflow, exp_unf);
            end
        end
        resetn = 1'b1;
        rd_valid = 1'b0;
        get_return_data = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_full();
        test_wrap();
        test_simultaneous();
        test_underflow();
        test_pacing();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
